// File: rtl/color_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : color_seq_pkg
// Purpose  : Shared definitions for the colour sequencer: FSM state encoding,
//            the 16-entry 12-bit base palette and the grey-ramp helper.
// Contents : seq_state_t     - MANUAL / AUTO_RUN / AUTO_PAUSE
//            c_BASE_PALETTE  - 16 x 12-bit {R,G,B}, entry 0 in the LSBs
//            base_color(i)   - palette lookup
//            ramp_color(k)   - grey level k replicated on R, G and B
// Revision : 1.0 - initial release
// ============================================================================
package color_seq_pkg;

    typedef enum logic [1:0] {
        MANUAL     = 2'd0,
        AUTO_RUN   = 2'd1,
        AUTO_PAUSE = 2'd2
    } seq_state_t;

    // Packed so it can be indexed with a variable part-select; entry 0 is
    // the rightmost 12 bits.
    localparam logic [16*12-1:0] c_BASE_PALETTE = {
        12'hCCC, 12'h004, 12'h040, 12'h400,
        12'h0F8, 12'h80F, 12'hF80, 12'h888,
        12'hFFF, 12'hF0F, 12'h0FF, 12'hFF0,
        12'h00F, 12'h0F0, 12'hF00, 12'h000
    };

    function automatic logic [11:0] base_color(input logic [3:0] i);
        return c_BASE_PALETTE[i*12 +: 12];
    endfunction

    function automatic logic [11:0] ramp_color(input logic [3:0] k);
        return {3{k}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_dwell_timer.sv
`default_nettype none
// ============================================================================
// Module   : frame_dwell_timer
// Purpose  : Counts frames while enabled and pulses o_wrap on the frame that
//            completes DWELL_FRAMES frames; the counter then restarts at 0.
// Ports    : clk, rst         - clock, asynchronous active-high reset
//            i_frame_start    - 1-cycle frame pulse
//            i_enable         - count frames only while high
//            i_clear          - force the count to 0 (wins over counting)
//            o_wrap           - combinational pulse in the wrapping cycle
// Revision : 1.0 - initial release
// ============================================================================
module frame_dwell_timer #(
    parameter int DWELL_FRAMES = 60
) (
    input  logic clk,
    input  logic rst,
    input  logic i_frame_start,
    input  logic i_enable,
    input  logic i_clear,
    output logic o_wrap
);

    // A single-frame dwell still needs a 1-bit register to stay legal.
    localparam int CNT_W = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DWELL_FRAMES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_tick;

    assign w_tick = i_frame_start & i_enable;
    assign o_wrap = w_tick & (r_cnt == c_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear || o_wrap) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/color_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : color_sequencer
// Purpose  : Chooses the 12-bit test colour for the VGA core: the manual
//            switch colour, or an automatic walk through a fixed palette.
//            Colour updates happen only in frame_start cycles (no tearing).
// Ports    : clk, rst        - clock, asynchronous active-high reset
//            frame_start     - 1-cycle pulse at start of vertical blank
//            mode_sel        - 0 = manual, 1 = auto
//            pause           - freezes the auto dwell timer
//            step_btn        - rising edge advances the palette index
//            manual_rgb[11:0]- {R,G,B} from switches
//            red_o/green_o/blue_o[3:0] - registered colour
//            palette_idx     - current sequence index
// Config   : COLOR_SEQ_RAMP_EN - appends a 16-step grey ramp to the palette
// Revision : 1.0 - initial release
// ============================================================================
module color_sequencer
    import color_seq_pkg::*;
#(
    parameter  int NUM_COLORS   = 8,
    parameter  int DWELL_FRAMES = 60,
`ifdef COLOR_SEQ_RAMP_EN
    localparam int SEQ_LEN      = NUM_COLORS + 16,
`else
    localparam int SEQ_LEN      = NUM_COLORS,
`endif
    localparam int IDX_W        = $clog2(SEQ_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             mode_sel,
    input  logic             pause,
    input  logic             step_btn,
    input  logic [11:0]      manual_rgb,
    output logic [3:0]       red_o,
    output logic [3:0]       green_o,
    output logic [3:0]       blue_o,
    output logic [IDX_W-1:0] palette_idx
);

    localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(SEQ_LEN - 1);

    seq_state_t       r_state;
    seq_state_t       w_state_next;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_next;
    logic [IDX_W-1:0] w_idx_inc;
    logic             r_step_q;
    logic             w_step_rise;
    logic             w_dwell_clr;
    logic             w_dwell_wrap;
    logic [11:0]      r_rgb;
    logic [11:0]      w_pal_rgb;

    assign w_step_rise = step_btn & ~r_step_q;
    // Explicit compare keeps non-power-of-2 lengths from reaching idx >= SEQ_LEN.
    assign w_idx_inc   = (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;

    frame_dwell_timer #(
        .DWELL_FRAMES (DWELL_FRAMES)
    ) u_dwell (
        .clk           (clk),
        .rst           (rst),
        .i_frame_start (frame_start),
        .i_enable      (r_state == AUTO_RUN),
        .i_clear       (w_dwell_clr),
        .o_wrap        (w_dwell_wrap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= MANUAL;
            r_idx    <= '0;
            r_step_q <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_idx    <= w_idx_next;
            r_step_q <= step_btn;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_dwell_clr  = 1'b0;
        case (r_state)
            MANUAL: begin
                // Holding the dwell at 0 here means auto mode always starts fresh.
                w_dwell_clr = 1'b1;
                if (mode_sel) begin
                    w_state_next = AUTO_RUN;
                    w_idx_next   = '0;
                end
            end
            AUTO_RUN: begin
                // A step coinciding with a dwell wrap advances only once;
                // the clear also beats the timer's own wrap-to-zero.
                if (w_step_rise) begin
                    w_idx_next  = w_idx_inc;
                    w_dwell_clr = 1'b1;
                end else if (w_dwell_wrap) begin
                    w_idx_next  = w_idx_inc;
                end
                if (!mode_sel) begin
                    w_state_next = MANUAL;
                end else if (pause) begin
                    w_state_next = AUTO_PAUSE;
                end
            end
            AUTO_PAUSE: begin
                if (w_step_rise) begin
                    w_idx_next  = w_idx_inc;
                    w_dwell_clr = 1'b1;
                end
                if (!mode_sel) begin
                    w_state_next = MANUAL;
                end else if (!pause) begin
                    w_state_next = AUTO_RUN;
                end
            end
            default: begin
                w_state_next = MANUAL;
            end
        endcase
    end

    // Palette lookup on the index being written this cycle, so a step and a
    // frame pulse in the same cycle display the new entry straight away.
`ifdef COLOR_SEQ_RAMP_EN
    logic [4:0] w_idx_ext;
    assign w_idx_ext = 5'(w_idx_next);
    always_comb begin
        w_pal_rgb = base_color(w_idx_ext[3:0]);
        if (w_idx_ext >= 5'(NUM_COLORS)) begin
            w_pal_rgb = ramp_color(4'(w_idx_ext - 5'(NUM_COLORS)));
        end
    end
`else
    logic [3:0] w_idx_ext;
    assign w_idx_ext = 4'(w_idx_next);
    always_comb begin
        w_pal_rgb = base_color(w_idx_ext);
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rgb <= '0;
        end else if (frame_start) begin
            r_rgb <= (r_state == MANUAL) ? manual_rgb : w_pal_rgb;
        end
    end

    assign red_o       = r_rgb[11:8];
    assign green_o     = r_rgb[7:4];
    assign blue_o      = r_rgb[3:0];
    assign palette_idx = r_idx;

endmodule
`default_nettype wire
